ssp_tx_fifo: RTL and testbench

Transmit FIFO for the synchronous serial port. It accepts bytes from the processor bus write side and presents them, in order, to the serial transmit/receive logic through the `TxData` / `tx_ready` / `transmit_complete` handshake. It holds the head byte stable for a whole 8-bit transmission and pops it only when that transmission completes. It sits directly upstream of the transmit/receive logic.

---
 rtl/ssp_pkg.sv | 22 ++
 rtl/ssp_tx_fifo_if.sv | 47 ++++
 rtl/ssp_fifo_mem.sv | 33 +++
 rtl/ssp_tx_fifo.sv | 103 ++++++++++
 tb/tb_ssp_tx_fifo.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ssp_pkg.sv
// ssp_pkg
// Shared definitions for the synchronous serial port FIFOs (transmit now,
// receive later): default data width and depth, the byte type, and the
// helper functions that size FIFO pointers and occupancy counters.
package ssp_pkg;

    localparam int SSP_DATA_W     = 8;
    localparam int SSP_FIFO_DEPTH = 4;

    typedef logic [SSP_DATA_W-1:0] ssp_byte_t;

    // Pointer width for a power-of-two depth; pointers wrap naturally.
    function automatic int ssp_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Counter needs one extra bit to represent "full" (count == depth).
    function automatic int ssp_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ssp_tx_fifo_if.sv
// ssp_tx_fifo_if
// Bus-side and serial-side signals of the SSP transmit FIFO.
//   PSEL, PWRITE, PWDATA : processor write port (push on PSEL & PWRITE)
//   transmit_complete    : from serial logic, low while a byte shifts out
//   TxData, tx_ready     : head byte and "unsent byte available"
//   SSPTXINTR            : transmit interrupt, high when not full
//   tx_full, tx_empty    : occupancy flags
//   TXOVF                : sticky overflow flag, only with SSP_TXFIFO_OVF_EN
// Modports: master = bus/serial side driving the FIFO, slave = the FIFO.
interface ssp_tx_fifo_if
    import ssp_pkg::*;
#(
    parameter int WIDTH = SSP_DATA_W
) ();

    logic             PSEL;
    logic             PWRITE;
    logic [WIDTH-1:0] PWDATA;
    logic             transmit_complete;
    logic [WIDTH-1:0] TxData;
    logic             tx_ready;
    logic             SSPTXINTR;
    logic             tx_full;
    logic             tx_empty;
`ifdef SSP_TXFIFO_OVF_EN
    logic             TXOVF;

    modport master (
        output PSEL, PWRITE, PWDATA, transmit_complete,
        input  TxData, tx_ready, SSPTXINTR, tx_full, tx_empty, TXOVF
    );
    modport slave (
        input  PSEL, PWRITE, PWDATA, transmit_complete,
        output TxData, tx_ready, SSPTXINTR, tx_full, tx_empty, TXOVF
    );
`else
    modport master (
        output PSEL, PWRITE, PWDATA, transmit_complete,
        input  TxData, tx_ready, SSPTXINTR, tx_full, tx_empty
    );
    modport slave (
        input  PSEL, PWRITE, PWDATA, transmit_complete,
        output TxData, tx_ready, SSPTXINTR, tx_full, tx_empty
    );
`endif

endinterface

// File: rtl/ssp_fifo_mem.sv
// ssp_fifo_mem
// DEPTH x WIDTH register array shared by the SSP FIFOs.
//   clk   : write clock
//   we    : write enable
//   waddr : write address, wdata : write data (synchronous write)
//   raddr : read address,  rdata : read data (combinational read)
// Storage is not reset; contents are meaningless until written.
module ssp_fifo_mem
    import ssp_pkg::*;
#(
    parameter int DEPTH = SSP_FIFO_DEPTH,
    parameter int WIDTH = SSP_DATA_W,
    parameter int AW    = ssp_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ssp_tx_fifo.sv
// ssp_tx_fifo
// Transmit FIFO for the synchronous serial port. Bytes written on the bus
// side are presented in order on TxData; the head byte is retired only when
// the serial logic signals completion (rising edge of transmit_complete).
//   PCLK    : system clock (same as the serial logic clock)
//   CLEAR_B : asynchronous active-low reset
//   bus     : ssp_tx_fifo_if.slave (write port, handshake, flags)
// Optional build macro SSP_TXFIFO_OVF_EN adds the sticky TXOVF flag.
module ssp_tx_fifo
    import ssp_pkg::*;
#(
    parameter int DEPTH = SSP_FIFO_DEPTH,
    parameter int WIDTH = SSP_DATA_W
) (
    input logic           PCLK,
    input logic           CLEAR_B,
    ssp_tx_fifo_if.slave  bus
);

    localparam int PW = ssp_ptr_w(DEPTH);
    localparam int CW = ssp_cnt_w(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             tc_q;
    logic             wr_req;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head;

    assign full   = (count == CNT_FULL);
    assign empty  = (count == '0);
    assign wr_req = bus.PSEL & bus.PWRITE;
    // Full comes from the registered count, so a write while full is
    // rejected even if a pop frees a slot in the same cycle.
    assign push   = wr_req & ~full;
    // Completion is the rising edge of transmit_complete; ignored when empty.
    assign pop    = bus.transmit_complete & ~tc_q & ~empty;

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            tc_q   <= 1'b1;
        end else begin
            tc_q <= bus.transmit_complete;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    ssp_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (PW)
    ) u_mem (
        .clk   (PCLK),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.PWDATA),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign bus.TxData    = head;
    // Already reflects post-pop occupancy in the pop cycle so the serial
    // logic does not restart on the byte being retired.
    assign bus.tx_ready  = (count > {{(CW-1){1'b0}}, pop});
    assign bus.tx_empty  = empty;
    assign bus.tx_full   = full;
    assign bus.SSPTXINTR = ~full;

`ifdef SSP_TXFIFO_OVF_EN
    logic ovf_q;

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            ovf_q <= 1'b0;
        end else if (wr_req & full) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.TXOVF = ovf_q;
`endif

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// tb_ssp_tx_fifo
// Self-checking bench for ssp_tx_fifo: a directed vector table, hand-written
// corner sequences and randomized traffic, all compared against a queue-based
// reference model. Set SSP_TXFIFO_OVF_EN to also check TXOVF.
module tb_ssp_tx_fifo;
    import ssp_pkg::*;

    localparam int DEPTH = SSP_FIFO_DEPTH;

    logic PCLK = 1'b0;
    logic CLEAR_B;

    ssp_tx_fifo_if #(.WIDTH(SSP_DATA_W)) bus ();

    ssp_tx_fifo #(.DEPTH(DEPTH), .WIDTH(SSP_DATA_W)) dut (
        .PCLK    (PCLK),
        .CLEAR_B (CLEAR_B),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;

    // Reference model: the FIFO is just an ordered queue of unsent bytes.
    ssp_byte_t model_q[$];
    bit        model_tc_prev;
    bit        model_ovf;

    typedef struct {
        bit        psel;
        bit        tc;
        ssp_byte_t d;
        int        n;
        bit        e_ready;
        bit        e_empty;
        bit        e_full;
        bit        chk_d;
        ssp_byte_t e_d;
    } vec_t;

    vec_t vec[$];

    function automatic vec_t v(bit ps, bit tc, ssp_byte_t d, int n, bit rdy,
                               bit emp, bit ful, bit cd, ssp_byte_t ed);
        vec_t r;
        r.psel = ps; r.tc = tc; r.d = d; r.n = n; r.e_ready = rdy;
        r.e_empty = emp; r.e_full = ful; r.chk_d = cd; r.e_d = ed;
        return r;
    endfunction

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_tc_prev = 1'b1;
        model_ovf     = 1'b0;
    endtask

    // One clock cycle: apply inputs, sample at the falling edge (pre-edge
    // view, including the combinational pop effect), compare with the model,
    // then advance the model across the rising edge.
    task automatic cycle(input bit psel, input bit pwrite, input ssp_byte_t d,
                         input bit tc, output logic s_ready, output logic s_empty,
                         output logic s_full, output logic s_intr,
                         output logic [7:0] s_data);
        int n;
        bit m_full, m_pop, m_push;
        bus.PSEL              = psel;
        bus.PWRITE            = pwrite;
        bus.PWDATA            = d;
        bus.transmit_complete = tc;
        @(negedge PCLK);
        n      = model_q.size();
        m_full = (n == DEPTH);
        m_pop  = tc && !model_tc_prev && (n > 0);
        m_push = psel && pwrite && !m_full;
        s_ready = bus.tx_ready;
        s_empty = bus.tx_empty;
        s_full  = bus.tx_full;
        s_intr  = bus.SSPTXINTR;
        s_data  = bus.TxData;
        chk1("m_empty", bus.tx_empty, n == 0);
        chk1("m_full", bus.tx_full, m_full);
        chk1("m_intr", bus.SSPTXINTR, !m_full);
        chk1("m_ready", bus.tx_ready, (n - int'(m_pop)) > 0);
        if (n > 0) chk8("m_txdata", bus.TxData, model_q[0]);
`ifdef SSP_TXFIFO_OVF_EN
        chk1("m_txovf", bus.TXOVF, model_ovf);
`endif
        @(posedge PCLK);
        if (psel && pwrite && m_full) model_ovf = 1'b1;
        if (m_pop) void'(model_q.pop_front());
        if (m_push) model_q.push_back(d);
        model_tc_prev = tc;
        #1;
    endtask

    logic       s_ready, s_empty, s_full, s_intr;
    logic [7:0] s_data;

    initial begin
        bus.PSEL              = 1'b0;
        bus.PWRITE            = 1'b0;
        bus.PWDATA            = '0;
        bus.transmit_complete = 1'b1;
        CLEAR_B               = 1'b0;
        model_reset();
        repeat (2) @(posedge PCLK);
        #1 CLEAR_B = 1'b1;

        // Directed table: reset, spurious completion, single byte, fill/overflow, drain.
        vec.push_back(v(0, 1, 8'h00, 1, 0, 1, 0, 0, 8'h00));
        vec.push_back(v(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00));
        vec.push_back(v(0, 1, 8'h00, 1, 0, 1, 0, 0, 8'h00));
        vec.push_back(v(1, 1, 8'hA5, 1, 0, 1, 0, 0, 8'h00));
        vec.push_back(v(0, 1, 8'h00, 1, 1, 0, 0, 1, 8'hA5));
        vec.push_back(v(0, 0, 8'h00, 8, 1, 0, 0, 1, 8'hA5));
        vec.push_back(v(0, 1, 8'h00, 1, 0, 0, 0, 1, 8'hA5));
        vec.push_back(v(0, 1, 8'h00, 1, 0, 1, 0, 0, 8'h00));
        vec.push_back(v(1, 1, 8'h11, 1, 0, 1, 0, 0, 8'h00));
        vec.push_back(v(1, 1, 8'h22, 1, 1, 0, 0, 1, 8'h11));
        vec.push_back(v(1, 1, 8'h33, 1, 1, 0, 0, 1, 8'h11));
        vec.push_back(v(1, 1, 8'h44, 1, 1, 0, 0, 1, 8'h11));
        vec.push_back(v(1, 1, 8'h55, 1, 1, 0, 1, 1, 8'h11));
        vec.push_back(v(0, 1, 8'h00, 1, 1, 0, 1, 1, 8'h11));
        vec.push_back(v(0, 0, 8'h00, 1, 1, 0, 1, 1, 8'h11));
        vec.push_back(v(0, 1, 8'h00, 1, 1, 0, 1, 1, 8'h11));
        vec.push_back(v(0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h22));
        vec.push_back(v(0, 1, 8'h00, 1, 1, 0, 0, 1, 8'h22));
        vec.push_back(v(0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h33));
        vec.push_back(v(0, 1, 8'h00, 1, 1, 0, 0, 1, 8'h33));
        vec.push_back(v(0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h44));
        vec.push_back(v(0, 1, 8'h00, 1, 0, 0, 0, 1, 8'h44));
        vec.push_back(v(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00));
        vec.push_back(v(0, 1, 8'h00, 1, 0, 1, 0, 0, 8'h00));

        for (int i = 0; i < vec.size(); i++) begin
            for (int r = 0; r < vec[i].n; r++) begin
                cycle(vec[i].psel, vec[i].psel, vec[i].d, vec[i].tc,
                      s_ready, s_empty, s_full, s_intr, s_data);
                chk1("vec_ready", s_ready, vec[i].e_ready);
                chk1("vec_empty", s_empty, vec[i].e_empty);
                chk1("vec_full", s_full, vec[i].e_full);
                chk1("vec_intr", s_intr, !vec[i].e_full);
                if (vec[i].chk_d) chk8("vec_txdata", s_data, vec[i].e_d);
            end
        end
`ifdef SSP_TXFIFO_OVF_EN
        chk1("ovf_sticky", bus.TXOVF, 1'b1);
`endif

        // Push in the same cycle as the completion edge.
        cycle(1, 1, 8'h01, 1, s_ready, s_empty, s_full, s_intr, s_data);
        cycle(1, 1, 8'h02, 1, s_ready, s_empty, s_full, s_intr, s_data);
        cycle(0, 0, 8'h00, 0, s_ready, s_empty, s_full, s_intr, s_data);
        cycle(1, 1, 8'h03, 1, s_ready, s_empty, s_full, s_intr, s_data);
        chk8("pp_head_before", s_data, 8'h01);
        cycle(0, 0, 8'h00, 1, s_ready, s_empty, s_full, s_intr, s_data);
        chk8("pp_head_after", s_data, 8'h02);
        cycle(0, 0, 8'h00, 0, s_ready, s_empty, s_full, s_intr, s_data);
        cycle(0, 0, 8'h00, 1, s_ready, s_empty, s_full, s_intr, s_data);
        chk1("pp_count2_ready", s_ready, 1'b1);
        cycle(0, 0, 8'h00, 0, s_ready, s_empty, s_full, s_intr, s_data);
        cycle(0, 0, 8'h00, 1, s_ready, s_empty, s_full, s_intr, s_data);
        chk8("pp_last", s_data, 8'h03);
        chk1("pp_last_ready", s_ready, 1'b0);
        cycle(0, 0, 8'h00, 1, s_ready, s_empty, s_full, s_intr, s_data);
        chk1("pp_empty", s_empty, 1'b1);

        // Ten push/pop pairs across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 8'(i), 1, s_ready, s_empty, s_full, s_intr, s_data);
            cycle(0, 0, 8'h00, 0, s_ready, s_empty, s_full, s_intr, s_data);
            cycle(0, 0, 8'h00, 1, s_ready, s_empty, s_full, s_intr, s_data);
            chk8("wrap_order", s_data, 8'(i));
        end

        // Reset while a byte is shifting out.
        cycle(1, 1, 8'h7E, 1, s_ready, s_empty, s_full, s_intr, s_data);
        cycle(1, 1, 8'h7F, 1, s_ready, s_empty, s_full, s_intr, s_data);
        cycle(0, 0, 8'h00, 0, s_ready, s_empty, s_full, s_intr, s_data);
        cycle(0, 0, 8'h00, 0, s_ready, s_empty, s_full, s_intr, s_data);
        #2 CLEAR_B = 1'b0;
        #1;
        chk1("rst_ready", bus.tx_ready, 1'b0);
        chk1("rst_empty", bus.tx_empty, 1'b1);
        chk1("rst_full", bus.tx_full, 1'b0);
        chk1("rst_intr", bus.SSPTXINTR, 1'b1);
`ifdef SSP_TXFIFO_OVF_EN
        chk1("rst_txovf", bus.TXOVF, 1'b0);
`endif
        model_reset();
        @(posedge PCLK);
        #1 CLEAR_B = 1'b1;
        cycle(0, 0, 8'h00, 0, s_ready, s_empty, s_full, s_intr, s_data);
        cycle(0, 0, 8'h00, 1, s_ready, s_empty, s_full, s_intr, s_data);
        cycle(0, 0, 8'h00, 1, s_ready, s_empty, s_full, s_intr, s_data);
        chk1("rst_after_ready", s_ready, 1'b0);
        chk1("rst_after_empty", s_empty, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  8'($urandom), $urandom_range(0, 2) != 0,
                  s_ready, s_empty, s_full, s_intr, s_data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
